// File: rtl/gray_pkg.sv
// Shared gray-pointer helpers and receiver FSM states.
// Functions operate on a PTR_MAX_W-wide zero-extended value; callers truncate to their width.
package gray_pkg;

    localparam int PTR_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESYNC = 2'd1,
        ST_TRACK  = 2'd2
    } state_t;

    // Zero upper bits decode to zero, so one wide decoder serves every N.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int popcount(input logic [PTR_MAX_W-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_ptr_receiver_if.sv
// Pointer input and decoded-pointer output bundle of the gray pointer receiver.
// master = pointer source / monitor side, slave = receiver.
interface gray_ptr_receiver_if #(
  parameter int N = 8
);
  logic [N-1:0] gray_in;
  logic         en;
  logic         err_clr;
  logic [N-1:0] bin_out;
  logic         bin_valid;
  logic [N-1:0] delta;
  logic         gray_err;
  logic         err_sticky;

  modport master (
    output gray_in, en, err_clr,
    input  bin_out, bin_valid, delta, gray_err, err_sticky
  );

  modport slave (
    input  gray_in, en, err_clr,
    output bin_out, bin_valid, delta, gray_err, err_sticky
  );
endinterface

// File: rtl/gray_sync.sv
// N-bit multi-flop synchroniser for a foreign-domain gray pointer.
// Latency SYNC_STAGES clk edges; no backpressure.
module gray_sync #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  logic [N-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[SYNC_STAGES-1];
endmodule

// File: rtl/gray_ptr_receiver.sv
// Synchronises and decodes a gray pointer, reports step size and flags multi-bit jumps.
// Latency SYNC_STAGES+1 clk edges from first sample to bin_valid; no backpressure (en only gates tracking).
module gray_ptr_receiver
  import gray_pkg::*;
#(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  gray_ptr_receiver_if.slave p
);
  logic [N-1:0] gs;
  logic [N-1:0] b;
  logic [N-1:0] prev_gray;
  logic [N-1:0] bin_r;
  logic [N-1:0] delta_r;
  logic         valid_r;
  logic         err_r;
  logic         sticky_r;
  state_t       state;
  state_t       state_nxt;
  logic         capture;
  logic         check;
  logic         hamm_err;

  gray_sync #(
    .N           (N),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (p.gray_in),
    .q   (gs)
  );

  assign b        = N'(gray2bin(PTR_MAX_W'(gs)));
  assign hamm_err = check && (popcount(PTR_MAX_W'(gs ^ prev_gray)) > 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // RESYNC captures without a Hamming check: prev_gray is stale after idle/reset.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    check     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (p.en) state_nxt = ST_RESYNC;
      end
      ST_RESYNC: begin
        capture   = 1'b1;
        state_nxt = p.en ? ST_TRACK : ST_IDLE;
      end
      ST_TRACK: begin
        if (!p.en) begin
          state_nxt = ST_IDLE;
        end else if (gs != prev_gray) begin
          capture = 1'b1;
          check   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_r     <= '0;
      delta_r   <= '0;
      prev_gray <= '0;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      sticky_r  <= 1'b0;
    end else begin
      valid_r  <= capture;
      err_r    <= hamm_err;
      sticky_r <= hamm_err | (sticky_r & ~p.err_clr);
      if (capture) begin
        bin_r     <= b;
        delta_r   <= b - bin_r;
        prev_gray <= gs;
      end
    end
  end

  assign p.bin_out    = bin_r;
  assign p.delta      = delta_r;
  assign p.bin_valid  = valid_r;
  assign p.gray_err   = err_r;
  assign p.err_sticky = sticky_r;
endmodule
